// File: rtl/barrel_pkg.sv
// ----------------------------------------------------------------------------
// barrel_pkg
// Shared definitions for the pipelined barrel shifter:
//   - op encodings carried through the pipe alongside the data
//   - stage_shift(): one fixed-distance shift/rotate step, written once at a
//     generous maximum width so every stage instance of any DWIDTH can share it
// ----------------------------------------------------------------------------
package barrel_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_SLL = 3'd0;
    localparam op_t OP_SRL = 3'd1;
    localparam op_t OP_SRA = 3'd2;
    localparam op_t OP_ROL = 3'd3;
    localparam op_t OP_ROR = 3'd4;
    // 3'd5..3'd7 are PASS: data goes through untouched regardless of shamt.

    // Upper bound on the operand width the helper can handle. Callers
    // zero-extend their operand into this width and truncate the result.
    localparam int MAX_DWIDTH = 256;

    // Shift/rotate 'data' (valid in the low 'width' bits) by 'amount' places.
    // 'sign' is the MSB of the original operand, used as the SRA fill; it is
    // carried from stage 0 because earlier stages may already have moved the
    // MSB of the partially shifted value.
    function automatic logic [MAX_DWIDTH-1:0] stage_shift(
        input op_t                   op,
        input logic [MAX_DWIDTH-1:0] data,
        input logic                  sign,
        input int                    amount,
        input int                    width
    );
        logic [MAX_DWIDTH-1:0] mask;
        logic [MAX_DWIDTH-1:0] res;
        mask = {MAX_DWIDTH{1'b1}} >> (MAX_DWIDTH - width);
        case (op)
            OP_SLL:  res = (data << amount) & mask;
            OP_SRL:  res = data >> amount;
            // Ones land exactly on the vacated MSB positions of the window.
            OP_SRA:  res = (data >> amount) | (sign ? (mask & ~(mask >> amount)) : '0);
            OP_ROL:  res = ((data << amount) | (data >> (width - amount))) & mask;
            OP_ROR:  res = ((data >> amount) | (data << (width - amount))) & mask;
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// ----------------------------------------------------------------------------
// barrel_shift_stage
// Purely combinational single log-stage of the barrel shifter: when
// shift_en_i is set the operand is shifted/rotated by STEP places in the mode
// given by op_i, otherwise it passes through unchanged.
//
// Ports:
//   shift_en_i  this stage's shift-amount bit
//   op_i        operation mode (barrel_pkg encodings, 5..7 = PASS)
//   sign_i      MSB of the original operand (SRA fill value)
//   data_i      operand from the previous stage
//   data_o      stage result
// ----------------------------------------------------------------------------
module barrel_shift_stage
    import barrel_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int STEP   = 1
) (
    input  logic              shift_en_i,
    input  op_t               op_i,
    input  logic              sign_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic [DWIDTH-1:0] data_o
);

    assign data_o = shift_en_i
                  ? DWIDTH'(stage_shift(op_i, MAX_DWIDTH'(data_i), sign_i, STEP, DWIDTH))
                  : data_i;

endmodule

// File: rtl/barrel_shift_pipe.sv
// ----------------------------------------------------------------------------
// barrel_shift_pipe
// Pipelined barrel shifter with one register stage per shift-amount bit and
// valid/ready flow control. Stage k shifts by 2^k when shamt bit k is set.
// Latency is log2(DWIDTH) cycles, throughput one op per cycle; bubbles are
// collapsed while the output is stalled, so the pipe holds S ops when full.
// DWIDTH must be a power of two and at least 2.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   in_valid    input op valid
//   in_ready    pipe can take an op this cycle (combinational from out_ready)
//   in_op       mode: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5..7 PASS
//   in_shamt    shift amount 0..DWIDTH-1
//   in_data     operand
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   out_data    shifted/rotated result
//   out_op      op that produced out_data
// ----------------------------------------------------------------------------
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter int DWIDTH = 8,
    localparam int SHW   = $clog2(DWIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [SHW-1:0]    in_shamt,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [2:0]        out_op
);

    localparam int S = SHW;

    // Per-stage pipeline registers.
    logic              valid_q [S];
    logic [DWIDTH-1:0] data_q  [S];
    op_t               op_q    [S];
    logic [SHW-1:0]    shamt_q [S];
    logic              sign_q  [S];

    // Combinational result of each stage's shifter, loaded into data_q.
    logic [DWIDTH-1:0] data_d  [S];

    // adv[k]: stage k may load this cycle (empty, or its content moves on).
    logic [S-1:0]      adv;

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_stage
            logic              valid_up;
            logic [DWIDTH-1:0] data_up;
            op_t               op_up;
            logic [SHW-1:0]    shamt_up;
            logic              sign_up;
            logic              adv_down;

            if (gi == 0) begin : g_first
                assign valid_up = in_valid;
                assign data_up  = in_data;
                assign op_up    = in_op;
                assign shamt_up = in_shamt;
                assign sign_up  = in_data[DWIDTH-1];
            end else begin : g_inner
                assign valid_up = valid_q[gi-1];
                assign data_up  = data_q[gi-1];
                assign op_up    = op_q[gi-1];
                assign shamt_up = shamt_q[gi-1];
                assign sign_up  = sign_q[gi-1];
            end

            if (gi == S - 1) begin : g_last_adv
                assign adv_down = out_ready;
            end else begin : g_inner_adv
                assign adv_down = adv[gi+1];
            end

            assign adv[gi] = !valid_q[gi] || adv_down;

            barrel_shift_stage #(
                .DWIDTH (DWIDTH),
                .STEP   (1 << gi)
            ) u_stage (
                .shift_en_i (shamt_up[gi]),
                .op_i       (op_up),
                .sign_i     (sign_up),
                .data_i     (data_up),
                .data_o     (data_d[gi])
            );

            // Operands are don't-care when valid_up is low, so the whole
            // stage loads on adv alone; a held stage never changes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q[gi] <= 1'b0;
                    data_q[gi]  <= '0;
                    op_q[gi]    <= '0;
                    shamt_q[gi] <= '0;
                    sign_q[gi]  <= 1'b0;
                end else if (adv[gi]) begin
                    valid_q[gi] <= valid_up;
                    data_q[gi]  <= data_d[gi];
                    op_q[gi]    <= op_up;
                    shamt_q[gi] <= shamt_up;
                    sign_q[gi]  <= sign_up;
                end
            end
        end
    endgenerate

    assign in_ready  = adv[0];
    assign out_valid = valid_q[S-1];
    assign out_data  = data_q[S-1];
    assign out_op    = op_q[S-1];

endmodule
